// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_pkg;

    localparam int MULT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage : mult_pkg

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negation: val_o = neg_i ? -val_i : val_i.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: val_i (W bits) input value, neg_i negate request, val_o (W bits) result.
module mult_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule : mult_sign_fix

// File: rtl/mult_iter_param.sv
// Iterative radix-2 shift-add multiplier, signed (sign-magnitude) or unsigned.
// Latency: done at T+WIDTH+1 after start at T; with MULT_EARLY_TERM_EN, T+n+1 where
//   n = max(1, bit length of |op_b|). Backpressure: none; start is ignored while busy.
// Ports: clk, resetn (sync active-low); start/signed_mode/op_a/op_b request; abort
//   cancels a run; busy high in RUN; done one-cycle pulse; product held 2*WIDTH result.
// Optional feature macro: MULT_EARLY_TERM_EN (stop once remaining multiplier bits are zero).
module mult_iter_param
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    mult_state_e          state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;      // multiplicand, shifted left each RUN cycle
    logic [WIDTH-1:0]     mplier_q, mplier_d;    // multiplier, shifted right each RUN cycle
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 neg_q, neg_d;          // result must be negated at the end

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   result;
    logic                 last_step;

    // Magnitudes of the operands; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned,
    // so the most negative value needs no special case.
    mult_sign_fix #(.W(WIDTH)) u_abs_a (
        .val_i (op_a),
        .neg_i (signed_mode & op_a[WIDTH-1]),
        .val_o (abs_a)
    );

    mult_sign_fix #(.W(WIDTH)) u_abs_b (
        .val_i (op_b),
        .neg_i (signed_mode & op_b[WIDTH-1]),
        .val_o (abs_b)
    );

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // The product register is loaded on the last RUN edge so that it is already
    // valid in the DONE cycle alongside the done pulse.
    mult_sign_fix #(.W(2*WIDTH)) u_res_fix (
        .val_i (acc_sum),
        .neg_i (neg_q),
        .val_o (result)
    );

`ifdef MULT_EARLY_TERM_EN
    // Finish once no set multiplier bit remains above the one consumed this cycle.
    assign last_step = ((mplier_q >> 1) == '0);
`else
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign cnt_d     = (state_q == RUN) ? cnt_q + CW'(1) : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        neg_d     = neg_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    mcand_d  = {{WIDTH{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    acc_d    = '0;
                    neg_d    = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (last_step) begin
                        state_d   = DONE;
                        product_d = result;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            neg_q     <= neg_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule : mult_iter_param

// File: tb/tb_mult_iter_param.sv
// Directed self-checking bench for mult_iter_param at WIDTH=32.
// Latency: expected done cycle counted from the start-sampling cycle T.
// Backpressure: n/a.
module tb_mult_iter_param;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

`ifdef MULT_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    mult_iter_param #(.WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .signed_mode (signed_mode),
        .op_a        (op_a),
        .op_b        (op_b),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected done offset from T: 33 in the full build, hand-computed n+1 with early termination.
    function automatic int lat(input int et_lat);
        return ET ? et_lat : 33;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents a request for one cycle (cycle T), returns at T+1.
    task automatic issue(input logic sm, input logic [31:0] a, input logic [31:0] b, input logic ab);
        start       = 1'b1;
        signed_mode = sm;
        op_a        = a;
        op_b        = b;
        abort       = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Entered at T+1; returns in the DONE cycle. inject>0 pulses a stray start in that cycle.
    task automatic wait_done(input string tag, input logic [63:0] exp_prod, input int exp_lat,
                             input int inject);
        logic [63:0] prev;
        int          cycles;
        bit          busy_ok;
        bit          hold_ok;
        prev    = product;
        cycles  = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (done !== 1'b1 && cycles < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (product !== prev) hold_ok = 1'b0;
            if (cycles == inject) begin
                start = 1'b1;
                op_a  = 32'd100;
                op_b  = 32'd100;
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        chk({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
        chk({tag, "_product"}, product, exp_prod);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, "_busy_in_run"}, 64'(busy_ok), 64'd1);
        chk({tag, "_product_hold"}, 64'(hold_ok), 64'd1);
    endtask

    task automatic do_mul(input string tag, input logic sm, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_prod, input int exp_lat);
        issue(sm, a, b, 1'b0);
        wait_done(tag, exp_prod, exp_lat, 0);
    endtask

    // From the DONE cycle, step once and confirm the block is back in IDLE.
    task automatic settle(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic no_done(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        int          abort_at;

        resetn      = 1'b0;
        start       = 1'b1;
        signed_mode = 1'b0;
        op_a        = 32'd9;
        op_b        = 32'd9;
        abort       = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_start_discarded", 64'(busy), 64'd0);

        // abort while idle does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'd0);

        do_mul("u3x5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, lat(4));
        settle("u3x5");
        do_mul("s_m7x6", 1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, lat(4));
        settle("s_m7x6");
        do_mul("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, lat(33));
        settle("u_max");
        do_mul("s_5xm3", 1'b1, 32'd5, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1, lat(3));
        settle("s_5xm3");
        do_mul("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, lat(2));
        settle("s_m1xm1");
        do_mul("s_minx1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, lat(2));
        settle("s_minx1");
        do_mul("u_8e7x2", 1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, lat(3));
        settle("u_8e7x2");
        do_mul("u_bx0", 1'b0, 32'h1234, 32'd0, 64'd0, lat(2));
        settle("u_bx0");
        do_mul("u_1xmsb", 1'b0, 32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, lat(33));
        settle("u_1xmsb");

        // start and abort together in IDLE: start wins
        issue(1'b0, 32'h1234, 32'd1, 1'b1);
        wait_done("start_abort", 64'h0000_0000_0000_1234, lat(2), 0);
        settle("start_abort");

        // most negative squared, then a back-to-back start in the DONE cycle
        do_mul("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, lat(33));
        issue(1'b0, 32'd7, 32'd9, 1'b0);
        wait_done("b2b", 64'd63, lat(5), 0);
        settle("b2b");

        // a start during RUN is ignored
        issue(1'b0, 32'd3, 32'd5, 1'b0);
        wait_done("run_start_ign", 64'h0000_0000_0000_000F, lat(4), 2);
        settle("run_start_ign");

        // abort mid-run
        abort_at = ET ? 3 : 10;
        prev     = product;
        issue(1'b0, 32'h1234, 32'h10, 1'b0);
        repeat (abort_at - 1) @(negedge clk);
        chk("abort_pre_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", product, prev);
        no_done("abort", 40);

        // reset mid-run, with a start presented during the reset cycle
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (4) @(negedge clk);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        resetn = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        chk("rst_start_discarded", 64'(busy), 64'd0);
        no_done("rst", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mult_iter_param

// File: doc/mult_iter_param.md
MULT_ITER_PARAM -- requirements
Module: mult_iter_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-003 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low, on clock clk.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin a multiply, sampled each cycle.
REQ-005 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 The block SHALL have ports op_a and op_b, inputs, WIDTH bits each: the multiplicand and the multiplier, sampled with start.
REQ-007 The block SHALL have port abort, input, 1 bit: cancels an operation in progress.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when product is updated.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: the registered result, held until the next done.

Function
REQ-011 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 A start seen in IDLE or DONE at cycle T SHALL be accepted: the block latches op_a, op_b and signed_mode and enters RUN at T+1.
REQ-013 When signed_mode=1 at acceptance, the block SHALL latch the absolute values of both operands and a result sign equal to sign(op_a) XOR sign(op_b).
REQ-014 Each RUN cycle SHALL examine one multiplier bit, LSB first: the block adds the shifted multiplicand to a 2*WIDTH-bit accumulator when the bit is 1, then shifts.
REQ-015 RUN SHALL last exactly WIDTH cycles; DONE SHALL occur at T+WIDTH+1 with done=1 and product updated in that same cycle.
REQ-016 In DONE, the result SHALL be the two's-complement negation of the accumulator when the latched result sign is 1, and the accumulator unchanged otherwise.
REQ-017 Signed -2^(WIDTH-1) x -2^(WIDTH-1) SHALL yield exactly 2^(2*WIDTH-2), with no overflow.
REQ-018 DONE SHALL last one cycle and then return to IDLE, unless start is high in DONE, in which case the block SHALL accept the new operation back-to-back (REQ-012).
REQ-019 start SHALL be ignored while in RUN.
REQ-020 abort in RUN SHALL return the block to IDLE on the next cycle, with no done pulse and product unchanged; abort in IDLE or DONE SHALL have no effect.
REQ-021 When start and abort are high in the same cycle in IDLE, start SHALL win.
REQ-022 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-023 product SHALL change only in the DONE cycle.

Reset
REQ-024 When resetn=0 at a clock edge, the state SHALL go to IDLE, and busy, done and product SHALL all go to 0, including in the middle of an operation.
REQ-025 Internal operand and accumulator registers SHALL be cleared to 0 on reset.
REQ-026 A start sampled in the same cycle as reset SHALL be discarded.

Configuration
REQ-027 When macro MULT_EARLY_TERM_EN is defined, RUN SHALL exit to DONE after the cycle in which the remaining unshifted multiplier bits become all zero, giving n = max(1, index of the highest set bit of |op_b| + 1) RUN cycles and done at T+n+1.
REQ-028 When MULT_EARLY_TERM_EN is undefined, RUN SHALL always last WIDTH cycles; product values SHALL be identical in both builds.

Structure
REQ-029 Package mult_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constant MULT_WIDTH_DEF = 32.
REQ-030 Sub-module mult_sign_fix (combinational, parametrised) SHALL perform the conditional two's-complement negation; it SHALL be instantiated for the operand absolute values and for the result correction.

Verification
REQ-031 Unsigned 3 x 5, start at T -> done at T+33, product = 0x00000000_0000000F, busy high T+1..T+32.
REQ-032 Signed -7 (0xFFFFFFF9) x 6 -> product = 0xFFFFFFFF_FFFFFFD6; unsigned 0xFFFFFFFF x 0xFFFFFFFF -> product = 0xFFFFFFFE_00000001.
REQ-033 Signed 0x80000000 x 0x80000000 -> product = 0x40000000_00000000; back-to-back start in the DONE cycle -> second done exactly WIDTH+1 cycles later.
REQ-034 Load 0x1234 x 0x10, then abort at T+10 -> idle at T+11, no done, product retains its previous value; then start during RUN -> ignored.
REQ-035 Assert resetn=0 at T+5 mid-run -> busy=0, done=0, product=0 on the next cycle; no done afterwards.
REQ-036 With MULT_EARLY_TERM_EN: op_b=1 -> done at T+2; op_b=0 -> done at T+2 with product 0; op_b=0x80000000 unsigned -> done at T+33.
